// File: rtl/memdep_storeset_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | memdep_storeset_if : rename/dispatch/issue/violation bus for the  |
// | store-set predictor.                 Rev 1.0                      |
// +------------------------------------------------------------------+
interface memdep_storeset_if #(
    parameter int ROB_SIZE  = 64,
    parameter int RENAME_W  = 4,
    parameter int ISSUE_W   = 2,
    parameter int DISP_W    = 4,
    parameter int SSIT_SIZE = 1024
);
    localparam int IDX_W    = $clog2(ROB_SIZE);
    localparam int FOLDPC_W = $clog2(SSIT_SIZE);

    logic                         i_stall;
    logic [RENAME_W-1:0]          i_lookup_vld;
    logic [RENAME_W*FOLDPC_W-1:0] i_lookup_foldpc;
    logic [RENAME_W-1:0]          i_lookup_is_store;
    logic [RENAME_W*IDX_W-1:0]    i_disp_robIdx;
    logic [RENAME_W-1:0]          o_shouldwait;
    logic [RENAME_W*IDX_W-1:0]    o_dep_robIdx;
    logic [ISSUE_W-1:0]           i_store_issued;
    logic [ISSUE_W*FOLDPC_W-1:0]  i_issue_foldpc;
    logic [ISSUE_W*IDX_W-1:0]     i_issue_robIdx;
    logic                         i_violation;
    logic [FOLDPC_W-1:0]          i_vio_store_foldpc;
    logic [FOLDPC_W-1:0]          i_vio_load_foldpc;
    logic [DISP_W*IDX_W-1:0]      i_read_robIdx;
    logic [DISP_W-1:0]            o_memdep_rdy;

    modport master (
        output i_stall, i_lookup_vld, i_lookup_foldpc, i_lookup_is_store, i_disp_robIdx,
        output i_store_issued, i_issue_foldpc, i_issue_robIdx,
        output i_violation, i_vio_store_foldpc, i_vio_load_foldpc, i_read_robIdx,
        input  o_shouldwait, o_dep_robIdx, o_memdep_rdy
    );

    modport slave (
        input  i_stall, i_lookup_vld, i_lookup_foldpc, i_lookup_is_store, i_disp_robIdx,
        input  i_store_issued, i_issue_foldpc, i_issue_robIdx,
        input  i_violation, i_vio_store_foldpc, i_vio_load_foldpc, i_read_robIdx,
        output o_shouldwait, o_dep_robIdx, o_memdep_rdy
    );
endinterface
`default_nettype wire

// File: rtl/memdep_storeset.sv
`default_nettype none
// +------------------------------------------------------------------+
// | memdep_storeset : store-set memory-dependence predictor (SSIT,    |
// | LFST, store-ready bits, rename->dispatch lookup). Rev 1.0         |
// +------------------------------------------------------------------+
module memdep_storeset #(
    parameter int ROB_SIZE     = 64,
    parameter int RENAME_W     = 4,
    parameter int ISSUE_W      = 2,
    parameter int DISP_W       = 4,
    parameter int SSIT_SIZE    = 1024,
    parameter int LFST_SIZE    = 32,
    parameter int CLEAR_PERIOD = 65536,
    parameter bit ENABLE       = 1'b1
) (
    input wire clk,
    input wire rst_n,
    memdep_storeset_if.slave bus
);
    localparam int IDX_W    = $clog2(ROB_SIZE);
    localparam int FOLDPC_W = $clog2(SSIT_SIZE);
    localparam int SSID_W   = $clog2(LFST_SIZE);
    localparam int CLR_W    = $clog2(CLEAR_PERIOD);

    logic [SSIT_SIZE-1:0] r_ssit_vld;
    logic [SSID_W-1:0]    r_ssit_ssid [SSIT_SIZE];
    logic [LFST_SIZE-1:0] r_lfst_vld;
    logic [IDX_W-1:0]     r_lfst_idx  [LFST_SIZE];
    logic [ROB_SIZE-1:0]  r_rdy;
    logic [SSID_W-1:0]    r_alloc;
    logic [CLR_W-1:0]     r_clr;

    logic [RENAME_W-1:0]  r_p_vld;
    logic [RENAME_W-1:0]  r_p_st;
    logic [RENAME_W-1:0]  r_p_ssv;
    logic [SSID_W-1:0]    r_p_ssid [RENAME_W];

    logic [FOLDPC_W-1:0]  w_lk_pc   [RENAME_W];
    logic [IDX_W-1:0]     w_d_idx   [RENAME_W];
    logic [IDX_W-1:0]     w_dep     [RENAME_W];
    logic [RENAME_W-1:0]  w_found;
    logic [RENAME_W-1:0]  w_ins;
    logic [RENAME_W-1:0]  w_lfst_wr;

    logic [FOLDPC_W-1:0]  w_iss_pc   [ISSUE_W];
    logic [IDX_W-1:0]     w_iss_idx  [ISSUE_W];
    logic [SSID_W-1:0]    w_iss_ssid [ISSUE_W];
    logic [ISSUE_W-1:0]   w_iss_inv;

    logic                 w_s_vld, w_l_vld;
    logic [SSID_W-1:0]    w_s_ssid, w_l_ssid, w_new_ssid;
    logic                 w_wrap;
    logic                 w_bad_ins, w_bad_iss, w_bad_both;

    assign w_wrap = (r_clr == CLR_W'(CLEAR_PERIOD - 1));

    for (genvar g = 0; g < RENAME_W; g++) begin : g_slot
        assign w_lk_pc[g] = bus.i_lookup_foldpc[g*FOLDPC_W +: FOLDPC_W];
        assign w_d_idx[g] = bus.i_disp_robIdx[g*IDX_W +: IDX_W];
        assign bus.o_dep_robIdx[g*IDX_W +: IDX_W] = w_dep[g];
        assign w_ins[g] = r_p_vld[g] & r_p_st[g] & ~bus.i_stall & ~bus.i_violation;
        assign w_lfst_wr[g] = w_ins[g] & r_p_ssv[g];
    end

    for (genvar g = 0; g < ISSUE_W; g++) begin : g_iss
        assign w_iss_pc[g]   = bus.i_issue_foldpc[g*FOLDPC_W +: FOLDPC_W];
        assign w_iss_idx[g]  = bus.i_issue_robIdx[g*IDX_W +: IDX_W];
        assign w_iss_ssid[g] = r_ssit_ssid[w_iss_pc[g]];
        // Only drop the set's last store if it is still the one that issued.
        assign w_iss_inv[g]  = bus.i_store_issued[g] & r_ssit_vld[w_iss_pc[g]] &
                               r_lfst_vld[w_iss_ssid[g]] &
                               (r_lfst_idx[w_iss_ssid[g]] == w_iss_idx[g]);
    end

    assign bus.o_shouldwait = ENABLE ? w_found : '0;

    // Stage D: later (younger) matching store in the group overrides the LFST.
    always_comb begin
        for (int i = 0; i < RENAME_W; i++) begin
            w_found[i] = 1'b0;
            w_dep[i]   = '0;
            if (r_p_vld[i] && r_p_ssv[i]) begin
                if (r_lfst_vld[r_p_ssid[i]]) begin
                    w_found[i] = 1'b1;
                    w_dep[i]   = r_lfst_idx[r_p_ssid[i]];
                end
                for (int k = 0; k < i; k++) begin
                    if (r_p_vld[k] && r_p_st[k] && r_p_ssv[k] && (r_p_ssid[k] == r_p_ssid[i])) begin
                        w_found[i] = 1'b1;
                        w_dep[i]   = w_d_idx[k];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < DISP_W; p++) begin
            bus.o_memdep_rdy[p] = r_rdy[bus.i_read_robIdx[p*IDX_W +: IDX_W]];
            for (int j = 0; j < ISSUE_W; j++) begin
                if (bus.i_store_issued[j] && (w_iss_idx[j] == bus.i_read_robIdx[p*IDX_W +: IDX_W]))
                    bus.o_memdep_rdy[p] = 1'b1;
            end
        end
    end

    assign w_s_vld  = r_ssit_vld[bus.i_vio_store_foldpc];
    assign w_l_vld  = r_ssit_vld[bus.i_vio_load_foldpc];
    assign w_s_ssid = r_ssit_ssid[bus.i_vio_store_foldpc];
    assign w_l_ssid = r_ssit_ssid[bus.i_vio_load_foldpc];

    always_comb begin
        w_new_ssid = r_alloc;
        if (w_s_vld && w_l_vld)
            w_new_ssid = (w_s_ssid < w_l_ssid) ? w_s_ssid : w_l_ssid;
        else if (w_s_vld)
            w_new_ssid = w_s_ssid;
        else if (w_l_vld)
            w_new_ssid = w_l_ssid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_vld <= '0;
            r_p_st  <= '0;
            r_p_ssv <= '0;
            for (int i = 0; i < RENAME_W; i++) r_p_ssid[i] <= '0;
        end else if (bus.i_violation) begin
            r_p_vld <= '0;
        end else if (!bus.i_stall) begin
            r_p_vld <= bus.i_lookup_vld;
            r_p_st  <= bus.i_lookup_is_store;
            for (int i = 0; i < RENAME_W; i++) begin
                r_p_ssv[i]  <= r_ssit_vld[w_lk_pc[i]];
                r_p_ssid[i] <= r_ssit_ssid[w_lk_pc[i]];
            end
        end
    end

    // Aging clears first so that same-cycle training survives the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ssit_vld <= '0;
            r_alloc    <= '0;
            r_clr      <= '0;
        end else begin
            r_clr <= w_wrap ? '0 : r_clr + CLR_W'(1);
            if (w_wrap) r_ssit_vld <= '0;
            if (bus.i_violation) begin
                r_ssit_vld[bus.i_vio_store_foldpc] <= 1'b1;
                r_ssit_vld[bus.i_vio_load_foldpc]  <= 1'b1;
                if (!w_s_vld && !w_l_vld) r_alloc <= r_alloc + SSID_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bus.i_violation) begin
            r_ssit_ssid[bus.i_vio_store_foldpc] <= w_new_ssid;
            r_ssit_ssid[bus.i_vio_load_foldpc]  <= w_new_ssid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfst_vld <= '0;
        end else if (bus.i_violation) begin
            r_lfst_vld <= '0;
        end else begin
            for (int j = 0; j < ISSUE_W; j++)
                if (w_iss_inv[j]) r_lfst_vld[w_iss_ssid[j]] <= 1'b0;
            for (int i = 0; i < RENAME_W; i++)
                if (w_lfst_wr[i]) r_lfst_vld[r_p_ssid[i]] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < RENAME_W; i++)
            if (w_lfst_wr[i]) r_lfst_idx[r_p_ssid[i]] <= w_d_idx[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy <= '1;
        end else if (bus.i_violation) begin
            r_rdy <= '1;
        end else begin
            for (int j = 0; j < ISSUE_W; j++)
                if (bus.i_store_issued[j]) r_rdy[w_iss_idx[j]] <= 1'b1;
            for (int i = 0; i < RENAME_W; i++)
                if (w_ins[i]) r_rdy[w_d_idx[i]] <= 1'b0;
        end
    end

    always_comb begin
        w_bad_ins  = 1'b0;
        w_bad_iss  = 1'b0;
        w_bad_both = 1'b0;
        for (int i = 0; i < RENAME_W; i++)
            if (w_ins[i] && !r_rdy[w_d_idx[i]]) w_bad_ins = 1'b1;
        for (int j = 0; j < ISSUE_W; j++) begin
            if (bus.i_store_issued[j] && r_rdy[w_iss_idx[j]]) w_bad_iss = 1'b1;
            for (int i = 0; i < RENAME_W; i++)
                if (w_ins[i] && bus.i_store_issued[j] && (w_d_idx[i] == w_iss_idx[j]))
                    w_bad_both = 1'b1;
        end
    end

    a_legal_ready_use: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_bad_ins || w_bad_iss || w_bad_both));

endmodule
`default_nettype wire

// File: tb/tb_memdep_storeset.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_memdep_storeset : scoreboard bench for memdep_storeset.        |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_memdep_storeset;
    localparam int RENAME_W = 4;
    localparam int IDX_W    = 6;
    localparam int FPC_W    = 10;
    localparam int PERIOD   = 16;

    typedef struct {
        int          cyc;
        int          kind;
        int          port;
        logic        w;
        logic [5:0]  dep;
        string       nm;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    exp_t q[$];
    exp_t q_keep[$];

    memdep_storeset_if #(.ROB_SIZE(64), .RENAME_W(4), .ISSUE_W(2), .DISP_W(4), .SSIT_SIZE(1024)) bus ();

    memdep_storeset #(
        .ROB_SIZE(64), .RENAME_W(4), .ISSUE_W(2), .DISP_W(4), .SSIT_SIZE(1024),
        .LFST_SIZE(4), .CLEAR_PERIOD(PERIOD), .ENABLE(1'b1)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        logic       got_w;
        logic [5:0] got_d;
        q_keep = {};
        foreach (q[n]) begin
            if (q[n].cyc == cyc) begin
                checks++;
                if (q[n].kind == 0) begin
                    got_w = bus.o_shouldwait[q[n].port];
                    got_d = bus.o_dep_robIdx[q[n].port*IDX_W +: IDX_W];
                    if (got_w !== q[n].w || got_d !== q[n].dep) begin
                        errors++;
                        $display("FAIL %s: got wait=%0b dep=%0d, expected wait=%0b dep=%0d",
                                 q[n].nm, got_w, got_d, q[n].w, q[n].dep);
                    end
                end else begin
                    got_w = bus.o_memdep_rdy[q[n].port];
                    if (got_w !== q[n].w) begin
                        errors++;
                        $display("FAIL %s: got rdy=%0b, expected rdy=%0b", q[n].nm, got_w, q[n].w);
                    end
                end
            end else if (q[n].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: expectation for cycle %0d never sampled", q[n].nm, q[n].cyc);
            end else begin
                q_keep.push_back(q[n]);
            end
        end
        q = q_keep;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        bus.i_lookup_vld      = '0;
        bus.i_lookup_is_store = '0;
        bus.i_store_issued    = '0;
        bus.i_violation       = 1'b0;
    endtask

    task automatic wait_phase(int p);
        while ((cyc % PERIOD) != p) next_cycle();
    endtask

    task automatic lookup(int s, logic [9:0] pc, logic st);
        bus.i_lookup_vld[s]             = 1'b1;
        bus.i_lookup_is_store[s]        = st;
        bus.i_lookup_foldpc[s*FPC_W +: FPC_W] = pc;
    endtask

    task automatic disp(int s, logic [5:0] idx);
        bus.i_disp_robIdx[s*IDX_W +: IDX_W] = idx;
    endtask

    task automatic violate(logic [9:0] sp, logic [9:0] lp);
        bus.i_violation        = 1'b1;
        bus.i_vio_store_foldpc = sp;
        bus.i_vio_load_foldpc  = lp;
    endtask

    task automatic issue(int p, logic [9:0] pc, logic [5:0] idx);
        bus.i_store_issued[p]              = 1'b1;
        bus.i_issue_foldpc[p*FPC_W +: FPC_W] = pc;
        bus.i_issue_robIdx[p*IDX_W +: IDX_W] = idx;
    endtask

    task automatic exp_slot(int s, logic w, logic [5:0] d, string nm);
        q.push_back('{cyc, 0, s, w, d, nm});
    endtask

    task automatic exp_rdy(int p, logic [5:0] idx, logic r, string nm);
        bus.i_read_robIdx[p*IDX_W +: IDX_W] = idx;
        q.push_back('{cyc, 1, p, r, 6'd0, nm});
    endtask

    task automatic exp_aging_group(string tag);
        exp_slot(0, 1'b0, 6'd0,  {tag, "_s0"});
        exp_slot(1, 1'b0, 6'd0,  {tag, "_s1"});
        exp_slot(2, 1'b1, 6'd30, {tag, "_survivor"});
        exp_slot(3, 1'b0, 6'd0,  {tag, "_aged_out"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.i_stall = 1'b0;
        bus.i_lookup_vld = '0;
        bus.i_lookup_foldpc = '0;
        bus.i_lookup_is_store = '0;
        bus.i_disp_robIdx = '0;
        bus.i_store_issued = '0;
        bus.i_issue_foldpc = '0;
        bus.i_issue_robIdx = '0;
        bus.i_violation = 1'b0;
        bus.i_vio_store_foldpc = '0;
        bus.i_vio_load_foldpc = '0;
        bus.i_read_robIdx = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int s = 0; s < RENAME_W; s++) exp_slot(s, 1'b0, 6'd0, "reset_slot");
        exp_rdy(0, 6'd0, 1'b1, "reset_rdy0");
        exp_rdy(1, 6'd5, 1'b1, "reset_rdy5");
        exp_rdy(2, 6'd7, 1'b1, "reset_rdy7");
        exp_rdy(3, 6'd63, 1'b1, "reset_rdy63");

        // Train then predict, intra-group bypass, issue releases the set.
        wait_phase(1);
        violate(10'h12, 10'h34);
        next_cycle();
        lookup(0, 10'h12, 1'b1);
        next_cycle();
        disp(0, 6'd5);
        exp_slot(0, 1'b0, 6'd0, "first_store");
        lookup(0, 10'h34, 1'b0);
        next_cycle();
        disp(0, 6'd6);
        exp_slot(0, 1'b1, 6'd5, "train_predict");
        exp_rdy(0, 6'd5, 1'b0, "rdy_after_insert");
        lookup(0, 10'h12, 1'b1);
        lookup(2, 10'h34, 1'b0);
        next_cycle();
        disp(0, 6'd7);
        disp(2, 6'd9);
        exp_slot(0, 1'b1, 6'd5, "store_chain");
        exp_slot(1, 1'b0, 6'd0, "idle_slot1");
        exp_slot(2, 1'b1, 6'd7, "intra_bypass");
        exp_slot(3, 1'b0, 6'd0, "idle_slot3");
        next_cycle();
        issue(0, 10'h12, 6'd5);
        issue(1, 10'h12, 6'd7);
        exp_rdy(0, 6'd5, 1'b1, "issue_bypass5");
        exp_rdy(1, 6'd7, 1'b1, "issue_bypass7");
        exp_rdy(2, 6'd9, 1'b1, "load_not_tracked");
        next_cycle();
        exp_rdy(0, 6'd5, 1'b1, "rdy_reg5");
        exp_rdy(1, 6'd7, 1'b1, "rdy_reg7");
        lookup(1, 10'h34, 1'b0);
        next_cycle();
        disp(1, 6'd10);
        exp_slot(1, 1'b0, 6'd0, "issue_clears_lfst");

        // Merge: 0x12 in set 3, 0x34 in set 1; merging keeps set 1.
        wait_phase(1);
        violate(10'h34, 10'h40);
        next_cycle();
        violate(10'h41, 10'h42);
        next_cycle();
        violate(10'h12, 10'h43);
        next_cycle();
        violate(10'h12, 10'h34);
        next_cycle();
        violate(10'h60, 10'h61);
        next_cycle();
        lookup(0, 10'h12, 1'b1);
        lookup(1, 10'h61, 1'b0);
        lookup(2, 10'h34, 1'b0);
        lookup(3, 10'h43, 1'b0);
        next_cycle();
        disp(0, 6'd20); disp(1, 6'd21); disp(2, 6'd22); disp(3, 6'd23);
        exp_slot(0, 1'b0, 6'd0,  "merge_store");
        exp_slot(1, 1'b0, 6'd0,  "alloc_kept");
        exp_slot(2, 1'b1, 6'd20, "merge_min");
        exp_slot(3, 1'b0, 6'd0,  "merge_other");
        next_cycle();
        exp_rdy(3, 6'd20, 1'b0, "merge_insert_rdy");

        // Aging: train in the wrap cycle; old sets must be gone afterwards.
        wait_phase(PERIOD - 1);
        violate(10'h70, 10'h71);
        next_cycle();
        lookup(0, 10'h70, 1'b1);
        lookup(1, 10'h12, 1'b1);
        lookup(2, 10'h71, 1'b0);
        lookup(3, 10'h34, 1'b0);
        next_cycle();
        disp(0, 6'd30); disp(1, 6'd31); disp(2, 6'd32); disp(3, 6'd33);
        exp_aging_group("age");
        bus.i_stall = 1'b1;
        lookup(0, 10'h71, 1'b0);
        next_cycle();
        exp_aging_group("stall");
        exp_rdy(0, 6'd30, 1'b1, "stall_no_insert30");
        exp_rdy(1, 6'd31, 1'b1, "stall_no_insert31");
        lookup(0, 10'h71, 1'b0);
        next_cycle();
        bus.i_stall = 1'b0;
        exp_aging_group("unstall");
        lookup(0, 10'h71, 1'b0);
        next_cycle();
        disp(0, 6'd40);
        exp_slot(0, 1'b1, 6'd30, "lfst_predict");
        exp_rdy(0, 6'd30, 1'b0, "insert_rdy30");
        exp_rdy(1, 6'd31, 1'b0, "insert_rdy31");
        exp_rdy(2, 6'd32, 1'b1, "load_rdy32");

        // Reset in the middle of traffic.
        @(negedge clk);
        #1;
        lookup(0, 10'h71, 1'b0);
        rst_n = 1'b0;
        #1;
        for (int s = 0; s < RENAME_W; s++) exp_slot(s, 1'b0, 6'd0, "midreset_slot");
        exp_rdy(0, 6'd30, 1'b1, "midreset_rdy30");
        exp_rdy(1, 6'd31, 1'b1, "midreset_rdy31");
        exp_rdy(2, 6'd40, 1'b1, "midreset_rdy40");
        exp_rdy(3, 6'd0,  1'b1, "midreset_rdy0");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        next_cycle();
        next_cycle();

        foreach (q[n]) begin
            checks++;
            errors++;
            $display("FAIL %s: expectation left unchecked", q[n].nm);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/memdep_storeset.md
# memdep_storeset

Parametrised store-set memory-dependence predictor for the backend memory pipeline. It holds the SSIT (store-set ID table), the LFST (last-fetched-store table) and the per-ROB-entry store-ready bits, and adds a one-cycle rename-to-dispatch lookup pipeline with intra-group bypass, violation training and periodic SSIT aging. Rename supplies folded PCs. Dispatch receives wait/dependence predictions. The memory dispatch queue reads store readiness before IQ insertion.

## Interface
- ROB_SIZE, 64: ROB entries. IDX_W = log2(ROB_SIZE).
- RENAME_W, 4: rename/dispatch slots.
- ISSUE_W, 2: store-issue ports.
- DISP_W, 4: readiness read ports.
- SSIT_SIZE, 1024: SSIT entries. FOLDPC_W = log2(SSIT_SIZE).
- LFST_SIZE, 32: store sets. SSID_W = log2(LFST_SIZE).
- CLEAR_PERIOD, 65536: cycles between SSIT invalidations. Must be ≥2.
- ENABLE, 1: 0 forces o_shouldwait=0. Ready bits still operate.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- i_stall  in  1  holds the lookup pipeline register
- i_lookup_vld  in  RENAME_W  rename-slot lookup valid
- i_lookup_foldpc  in  RENAME_W*FOLDPC_W  folded PC per slot
- i_lookup_is_store  in  RENAME_W  slot is a store
- i_disp_robIdx  in  RENAME_W*IDX_W  ROB index allocated to the registered slots
- o_shouldwait  out  RENAME_W  registered slot must wait on a store
- o_dep_robIdx  out  RENAME_W*IDX_W  store it waits on
- i_store_issued  in  ISSUE_W  store issued
- i_issue_foldpc  in  ISSUE_W*FOLDPC_W  issued store folded PC
- i_issue_robIdx  in  ISSUE_W*IDX_W  issued store ROB index
- i_violation  in  1  memory-order violation, with pipeline flush
- i_vio_store_foldpc, i_vio_load_foldpc  in  FOLDPC_W each  violating pair
- i_read_robIdx  in  DISP_W*IDX_W  readiness query
- o_memdep_rdy  out  DISP_W  queried store has issued, or is not an in-flight store

## Operation
- **Stage R (rename):** for each slot, read SSIT[foldpc] to get {valid, ssid}. Capture {vld, is_store, ssv, ssid} into the pipe register when i_stall=0. Hold it when i_stall=1.
- **Stage D (dispatch), using the pipe register:**
  - A slot with vld and ssv waits on the youngest older slot k in the same group with vld_k, is_store_k, ssv_k and ssid_k==ssid. In that case o_dep_robIdx = i_disp_robIdx[k].
  - Otherwise it waits if LFST[ssid] is valid, with o_dep_robIdx = LFST[ssid].robIdx.
  - o_shouldwait = ENABLE & found.
- **Store insert in stage D (only when i_stall=0):**
  - Every store slot clears rdy[robIdx].
  - A store slot with ssv writes LFST[ssid] = {1, robIdx}. If several store slots share an ssid, the highest slot wins.
- **Store issue:** set rdy[robIdx]=1. Look up SSIT[i_issue_foldpc]; if it is valid and LFST[ssid] = {1, robIdx}, invalidate that LFST entry.
- **Violation training (s = store foldpc, l = load foldpc):**
  - Neither SSIT entry valid: both get ssid = alloc_ctr, and alloc_ctr increments modulo LFST_SIZE.
  - Exactly one valid: the other copies its ssid.
  - Both valid: both take the smaller ssid.
- **Violation flush:**
  - All rdy bits go to 1 and all LFST entries are invalidated.
  - Stage-D inserts and LFST writes that cycle are dropped.
  - The pipe register valid bits clear.
- **Aging:** clear_ctr counts every cycle. At CLEAR_PERIOD-1 it wraps to 0 and all SSIT valid bits clear. Training in the same cycle is still written, so the trained entries survive.
- **Readiness query:** o_memdep_rdy[i] = rdy[idx] OR (any i_store_issued[j] with i_issue_robIdx[j]==idx), i.e. same-cycle issue bypass.
- **Illegal, flagged by assertion:** inserting a store whose rdy bit is already 0; issuing an entry whose rdy bit is 1; inserting and issuing the same index in the same cycle.

## Timing
- **Reset values:** rdy all 1; SSIT and LFST valid bits 0; pipe register valid bits 0; alloc_ctr = 0; clear_ctr = 0. Consequently o_shouldwait=0, o_dep_robIdx=0 and o_memdep_rdy all 1. Reset asserted mid-operation clears all of these immediately.
- **Latency:** lookup in cycle N produces o_shouldwait/o_dep_robIdx combinationally from the pipe register in N+1.
- **Write visibility:**
  - SSIT writes (training, aging) become visible to lookups one cycle later. A same-cycle lookup reads the old value.
  - LFST and rdy writes become visible at stage D and on the query ports the next cycle.
  - Issue-to-rdy has zero-cycle visibility on o_memdep_rdy via the bypass.
- **Same-cycle priority:** violation > insert; issue and insert on different indices both apply.
- **Stall:** while i_stall=1, stage-D outputs remain stable and no inserts occur.

## Test plan
- **Reset:** assert rst_n=0 mid-traffic → next cycle o_shouldwait=0 and every o_memdep_rdy=1.
- **Train then predict:** violation with store foldpc 0x12, load foldpc 0x34 → both get ssid 0. Rename store 0x12 (robIdx 5) in cycle 2 and load 0x34 in cycle 3 → in cycle 4 the load slot has o_shouldwait=1, o_dep_robIdx=5.
- **Intra-group bypass:** slot0 = store 0x12 (robIdx 7), slot2 = load 0x34 (robIdx 9), same group → slot2 shows o_dep_robIdx=7, not the LFST value.
- **Issue clears the dependence:** issue robIdx 5 → o_memdep_rdy for robIdx 5 is 1 in the same cycle, and the LFST entry is invalidated, so a later load 0x34 gets o_shouldwait=0.
- **Merge:** the pair holds ssids 3 and 1, then a violation on that pair → both are set to 1; alloc_ctr is unchanged.
- **Aging:** with CLEAR_PERIOD=16, no lookup for 16 cycles → a load 0x34 gets o_shouldwait=0. An entry trained in the wrap cycle is still valid afterwards.
